mult_io_sequencer: RTL and testbench



---
 rtl/mult_seq_pkg.sv | 27 ++
 rtl/mult_io_sequencer_if.sv | 32 +++
 rtl/mult_seq_sign_fix.sv | 15 +
 rtl/mult_io_sequencer.sv | 146 ++++++++++++++
 tb/tb_mult_io_sequencer.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mult_seq_pkg.sv
// mult_seq_pkg
// Purpose : types and constants shared by the multiplier I/O sequencer.
// Contents: state_e    - sequencer states, 3-bit encoding
//           DEF_WIDTH  - default operand width
//           DEF_MUL_LAT- default multiplier latency
//           cnt_width  - width of the latency counter for a given latency
// Optional build macro used by the block: MULT_SEQ_SIGNED_EN.
package mult_seq_pkg;

    typedef enum logic [2:0] {
        LOAD_A = 3'd0,
        LOAD_B = 3'd1,
        MUL    = 3'd2,
        OUT_LO = 3'd3,
        OUT_HI = 3'd4
    } state_e;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_MUL_LAT = 1;

    // The counter must hold 0..MUL_LAT so the post-increment on the
    // capture cycle never wraps into a value that could be misread.
    function automatic int cnt_width(input int lat);
        return $clog2(lat + 1);
    endfunction

endpackage

// File: rtl/mult_io_sequencer_if.sv
// mult_io_sequencer_if
// Purpose : bundles the operand input stream, product output stream,
//           multiplier operand/product bus, enable and busy flag.
// Modports: slave  - the sequencer itself
//           master - pin wrapper / multiplier side that talks to it
// Signals : ena, in_data/in_valid/in_ready, out_data/out_valid/out_ready,
//           mul_a, mul_b, mul_p (2*WIDTH), busy.
interface mult_io_sequencer_if #(
    parameter int WIDTH = 8
) ();
    logic                   ena;
    logic [WIDTH-1:0]       in_data;
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       out_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [WIDTH-1:0]       mul_a;
    logic [WIDTH-1:0]       mul_b;
    logic [2*WIDTH-1:0]     mul_p;
    logic                   busy;

    modport slave (
        input  ena, in_data, in_valid, out_ready, mul_p,
        output in_ready, out_data, out_valid, mul_a, mul_b, busy
    );

    modport master (
        output ena, in_data, in_valid, out_ready, mul_p,
        input  in_ready, out_data, out_valid, mul_a, mul_b, busy
    );
endinterface

// File: rtl/mult_seq_sign_fix.sv
// mult_seq_sign_fix
// Purpose : combinational conditional two's-complement negate. Used as
//           abs() when neg_i is the operand's own sign bit, and as the
//           product sign restore when neg_i is signA^signB.
// Ports   : val_i [W] value in, neg_i negate request, res_o [W] result
//           (modulo 2^W, so the most-negative input maps to 2^(W-1)).
module mult_seq_sign_fix #(
    parameter int W = 8
) (
    input  logic [W-1:0] val_i,
    input  logic         neg_i,
    output logic [W-1:0] res_o
);
    assign res_o = neg_i ? (~val_i + 1'b1) : val_i;
endmodule

// File: rtl/mult_io_sequencer.sv
// mult_io_sequencer
// Purpose : accepts operand A then B as bytes over a valid/ready stream,
//           holds them on the multiplier inputs, waits MUL_LAT cycles,
//           captures the 2*WIDTH product and returns it low byte first
//           over a second valid/ready stream.
// Ports   : clk  - rising-edge clock
//           rst  - asynchronous active-high reset
//           bus  - mult_io_sequencer_if.slave (ena, input stream, output
//                  stream, mul_a/mul_b/mul_p, busy)
// Macro   : MULT_SEQ_SIGNED_EN - two's-complement operands; magnitudes go
//           to the multiplier and the sign is restored at capture.
module mult_io_sequencer
    import mult_seq_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int MUL_LAT = DEF_MUL_LAT
) (
    input  logic                clk,
    input  logic                rst,
    mult_io_sequencer_if.slave  bus
);
    localparam int             CNT_W    = cnt_width(MUL_LAT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_LAT - 1);

    state_e                 state_q, state_d;
    logic [WIDTH-1:0]       mul_a_q, mul_a_d;
    logic [WIDTH-1:0]       mul_b_q, mul_b_d;
    logic [2*WIDTH-1:0]     prod_q,  prod_d;
    logic [CNT_W-1:0]       cnt_q,   cnt_d;

    logic [WIDTH-1:0]       load_val;
    logic [2*WIDTH-1:0]     cap_val;
    logic                   in_ready;
    logic                   out_valid;

`ifdef MULT_SEQ_SIGNED_EN
    logic sign_a_q, sign_a_d;
    logic sign_b_q, sign_b_d;

    // One abs unit suffices: A and B both arrive on in_data.
    mult_seq_sign_fix #(.W(WIDTH)) u_abs (
        .val_i (bus.in_data),
        .neg_i (bus.in_data[WIDTH-1]),
        .res_o (load_val)
    );

    mult_seq_sign_fix #(.W(2*WIDTH)) u_neg (
        .val_i (bus.mul_p),
        .neg_i (sign_a_q ^ sign_b_q),
        .res_o (cap_val)
    );
`else
    assign load_val = bus.in_data;
    assign cap_val  = bus.mul_p;
`endif

    always_comb begin
        state_d   = state_q;
        mul_a_d   = mul_a_q;
        mul_b_d   = mul_b_q;
        prod_d    = prod_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
`ifdef MULT_SEQ_SIGNED_EN
        sign_a_d  = sign_a_q;
        sign_b_d  = sign_b_q;
`endif
        case (state_q)
            LOAD_A: begin
                in_ready = bus.ena;
                if (bus.ena && bus.in_valid) begin
                    mul_a_d = load_val;
`ifdef MULT_SEQ_SIGNED_EN
                    sign_a_d = bus.in_data[WIDTH-1];
`endif
                    state_d = LOAD_B;
                end
            end
            LOAD_B: begin
                in_ready = bus.ena;
                if (bus.ena && bus.in_valid) begin
                    mul_b_d = load_val;
`ifdef MULT_SEQ_SIGNED_EN
                    sign_b_d = bus.in_data[WIDTH-1];
`endif
                    cnt_d   = '0;
                    state_d = MUL;
                end
            end
            MUL: begin
                // Counter freezes with ena so the multiplier keeps its
                // full latency across a pause.
                if (bus.ena) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        prod_d  = cap_val;
                        state_d = OUT_LO;
                    end
                end
            end
            OUT_LO: begin
                out_valid = bus.ena;
                if (bus.ena && bus.out_ready) state_d = OUT_HI;
            end
            OUT_HI: begin
                out_valid = bus.ena;
                if (bus.ena && bus.out_ready) state_d = LOAD_A;
            end
            default: state_d = LOAD_A;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= LOAD_A;
            mul_a_q  <= '0;
            mul_b_q  <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
`ifdef MULT_SEQ_SIGNED_EN
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            mul_a_q  <= mul_a_d;
            mul_b_q  <= mul_b_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
`ifdef MULT_SEQ_SIGNED_EN
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
`endif
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = (state_q == OUT_HI) ? prod_q[2*WIDTH-1:WIDTH]
                                               : prod_q[WIDTH-1:0];
    assign bus.mul_a     = mul_a_q;
    assign bus.mul_b     = mul_b_q;
    assign bus.busy      = (state_q != LOAD_A);

endmodule

// File: tb/tb_mult_io_sequencer.sv
// tb_mult_io_sequencer
// Purpose : directed bench for mult_io_sequencer. Two instances: index 0
//           with MUL_LAT=1 (combinational multiplier model), index 1 with
//           MUL_LAT=3 (two-register pipelined multiplier model).
//           Expected product bytes are pushed to a scoreboard queue when
//           operands are sent and popped as the DUT returns bytes.
// Macro   : MULT_SEQ_SIGNED_EN switches the reference product to signed
//           and enables the signed directed steps.
module tb_mult_io_sequencer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mult_io_sequencer_if #(.WIDTH(8)) if1 ();
    mult_io_sequencer_if #(.WIDTH(8)) if3 ();

    mult_io_sequencer #(.WIDTH(8), .MUL_LAT(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
    mult_io_sequencer #(.WIDTH(8), .MUL_LAT(3)) dut3 (.clk(clk), .rst(rst), .bus(if3));

    // Per-instance drive and observe arrays, index 0 = dut1, 1 = dut3.
    logic       ena_t[2], in_valid_t[2], out_ready_t[2];
    logic [7:0] in_data_t[2];
    logic       in_ready_o[2], out_valid_o[2], busy_o[2];
    logic [7:0] out_data_o[2], mul_a_o[2];

    assign if1.ena = ena_t[0];       assign if3.ena = ena_t[1];
    assign if1.in_valid = in_valid_t[0]; assign if3.in_valid = in_valid_t[1];
    assign if1.in_data = in_data_t[0];   assign if3.in_data = in_data_t[1];
    assign if1.out_ready = out_ready_t[0]; assign if3.out_ready = out_ready_t[1];
    assign in_ready_o[0] = if1.in_ready;   assign in_ready_o[1] = if3.in_ready;
    assign out_valid_o[0] = if1.out_valid; assign out_valid_o[1] = if3.out_valid;
    assign out_data_o[0] = if1.out_data;   assign out_data_o[1] = if3.out_data;
    assign busy_o[0] = if1.busy;           assign busy_o[1] = if3.busy;
    assign mul_a_o[0] = if1.mul_a;         assign mul_a_o[1] = if3.mul_a;

    // Multiplier models.
    assign if1.mul_p = {8'b0, if1.mul_a} * {8'b0, if3.mul_b & 8'h00 | if1.mul_b};
    logic [15:0] pipe3_a, pipe3_b;
    always @(posedge clk) begin
        pipe3_a <= {8'b0, if3.mul_a} * {8'b0, if3.mul_b};
        pipe3_b <= pipe3_a;
    end
    assign if3.mul_p = pipe3_b;

    logic [7:0] sb_q[$];
    int errors = 0;
    int checks = 0;

    function automatic logic [15:0] ref_prod(input logic [7:0] a, input logic [7:0] b);
`ifdef MULT_SEQ_SIGNED_EN
        logic signed [15:0] sa, sb;
        sa = {{8{a[7]}}, a};
        sb = {{8{b[7]}}, b};
        return 16'(sa * sb);
`else
        return {8'b0, a} * {8'b0, b};
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input int s, input logic [7:0] d);
        int n;
        in_data_t[s]  = d;
        in_valid_t[s] = 1'b1;
        n = 0;
        while (!in_ready_o[s] && n < 20) begin
            tick();
            n++;
        end
        check("in_ready_on_send", 32'(in_ready_o[s]), 32'd1);
        tick();
        in_valid_t[s] = 1'b0;
    endtask

    task automatic load_pair(input int s, input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = ref_prod(a, b);
        sb_q.push_back(p[7:0]);
        sb_q.push_back(p[15:8]);
        send_byte(s, a);
        send_byte(s, b);
    endtask

    // Called right after the B-handshake edge; counts edges to out_valid.
    task automatic wait_out(input int s, input int exp_lat, input string tag);
        int n;
        n = 0;
        while (!out_valid_o[s] && n < 40) begin
            tick();
            n++;
        end
        check(tag, n, exp_lat);
    endtask

    task automatic recv_byte(input int s, input string tag);
        int n;
        logic [7:0] exp;
        out_ready_t[s] = 1'b1;
        n = 0;
        while (!out_valid_o[s] && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, 32'(out_valid_o[s]), 32'd1);
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd1);
        end else begin
            exp = sb_q.pop_front();
            check(tag, 32'(out_data_o[s]), 32'(exp));
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            ena_t[i] = 1'b1; in_valid_t[i] = 1'b0;
            out_ready_t[i] = 1'b0; in_data_t[i] = 8'h00;
        end
        tick();
        tick();
        // Reset state
        check("rst_in_ready", 32'(in_ready_o[0]), 32'd1);
        check("rst_out_valid", 32'(out_valid_o[0]), 32'd0);
        check("rst_busy", 32'(busy_o[1]), 32'd0);
        check("rst_mul_a", 32'(mul_a_o[0]), 32'd0);
        check("rst_out_data", 32'(out_data_o[1]), 32'd0);
        ena_t[0] = 1'b0;
        #1;
        check("rst_in_ready_ena0", 32'(in_ready_o[0]), 32'd0);
        ena_t[0] = 1'b1;
        #2;
        rst = 1'b0;
        tick();

        // Basic, MUL_LAT=1
        out_ready_t[0] = 1'b1;
        load_pair(0, 8'd12, 8'd13);
        check("basic_busy", 32'(busy_o[0]), 32'd1);
        wait_out(0, 1, "basic_latency");
        check("basic_lo_lit", 32'(out_data_o[0]), 32'h9C);
        recv_byte(0, "basic_lo");
        check("basic_hi_lit", 32'(out_data_o[0]), 32'h00);
        recv_byte(0, "basic_hi");
        check("basic_busy_after", 32'(busy_o[0]), 32'd0);
        check("basic_in_ready_after", 32'(in_ready_o[0]), 32'd1);

        // Max operands, MUL_LAT=3
        out_ready_t[1] = 1'b1;
        load_pair(1, 8'hFF, 8'hFF);
        wait_out(1, 3, "max_latency");
`ifndef MULT_SEQ_SIGNED_EN
        check("max_lo_lit", 32'(out_data_o[1]), 32'h01);
`endif
        recv_byte(1, "max_lo");
`ifndef MULT_SEQ_SIGNED_EN
        check("max_hi_lit", 32'(out_data_o[1]), 32'hFE);
`endif
        recv_byte(1, "max_hi");

        // Back-pressure in OUT_LO
        out_ready_t[1] = 1'b0;
        load_pair(1, 8'hFF, 8'hFF);
        wait_out(1, 3, "bp_latency");
        for (int i = 0; i < 4; i++) begin
            check("bp_out_valid", 32'(out_valid_o[1]), 32'd1);
            check("bp_out_data", 32'(out_data_o[1]), 32'(sb_q[0]));
            check("bp_in_ready", 32'(in_ready_o[1]), 32'd0);
            tick();
        end
        recv_byte(1, "bp_lo");
        recv_byte(1, "bp_hi");

        // Reset in LOAD_B
        send_byte(0, 8'h55);
        check("rstmid_busy_before", 32'(busy_o[0]), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rstmid_mul_a", 32'(mul_a_o[0]), 32'd0);
        check("rstmid_out_valid", 32'(out_valid_o[0]), 32'd0);
        check("rstmid_busy", 32'(busy_o[0]), 32'd0);
        check("rstmid_in_ready", 32'(in_ready_o[0]), 32'd1);
        #1;
        rst = 1'b0;
        tick();
        load_pair(0, 8'd2, 8'd3);
        wait_out(0, 1, "rstmid_latency");
        check("rstmid_lo_lit", 32'(out_data_o[0]), 32'h06);
        recv_byte(0, "rstmid_lo");
        recv_byte(0, "rstmid_hi");

        // ena freeze in MUL, MUL_LAT=3
        out_ready_t[1] = 1'b1;
        load_pair(1, 8'd7, 8'd9);
        tick();
        ena_t[1] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("frz_in_ready", 32'(in_ready_o[1]), 32'd0);
            check("frz_out_valid", 32'(out_valid_o[1]), 32'd0);
            tick();
        end
        ena_t[1] = 1'b1;
        wait_out(1, 2, "frz_remaining");
        recv_byte(1, "frz_lo");
        recv_byte(1, "frz_hi");

`ifdef MULT_SEQ_SIGNED_EN
        // Signed operands, MUL_LAT=1
        send_byte(0, 8'hFD);
        check("sgn_mag_a", 32'(mul_a_o[0]), 32'd3);
        in_data_t[0] = 8'h05;
        sb_q.push_back(8'hF1);
        sb_q.push_back(8'hFF);
        send_byte(0, 8'h05);
        wait_out(0, 1, "sgn_latency");
        recv_byte(0, "sgn1_lo");
        recv_byte(0, "sgn1_hi");
        load_pair(0, 8'h80, 8'h80);
        check("sgn_mag_min", 32'(mul_a_o[0]), 32'h80);
        wait_out(0, 1, "sgn2_latency");
        check("sgn2_lo_lit", 32'(out_data_o[0]), 32'h00);
        recv_byte(0, "sgn2_lo");
        check("sgn2_hi_lit", 32'(out_data_o[0]), 32'h40);
        recv_byte(0, "sgn2_hi");
`endif

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
